fifo_read_streamer: RTL

- Read-domain consumer that sits directly downstream of the async FIFO on clk_read.
- Drives the FIFO Read_enable from the FIFO empty flag and downstream credit, and absorbs the one-cycle RAM read latency in a 2-entry output buffer.
- Presents a valid/ready stream with packet framing: m_last on every PKT_LEN-th beat.
- Sustains 1 word/cycle with no loss or duplication under arbitrary backpressure.

---
 rtl/fifo_read_streamer_pkg.sv | 24 ++
 rtl/fifo_read_streamer_skid.sv | 78 +++++++
 rtl/fifo_read_streamer.sv | 78 +++++++
 3 files changed

// File: rtl/fifo_read_streamer_pkg.sv
// Shared definitions for the FIFO read-side streamer. These defaults must track
// the async FIFO the streamer is attached to.
package fifo_read_streamer_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_PKT_LEN    = 16;
  localparam int DEF_CNT_WIDTH  = 4;

  // FIFO RAM read latency in clk_read cycles. The credit check below and the
  // single inflight flop are built for exactly one cycle.
  localparam int RD_LAT = 1;

  typedef logic [1:0] occ_t;

  // Words the buffer will hold after this cycle if nothing new is issued:
  // current occupancy plus the word in flight, minus the word leaving.
  // Evaluated at 3 bits so occ=2 plus inflight=1 cannot wrap.
  function automatic logic [2:0] credit_sum(input occ_t occ, input logic inflight,
                                            input logic pop);
    return {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/fifo_read_streamer_skid.sv
// Two-entry in-order buffer that absorbs the FIFO read latency. Head is the
// word presented downstream; tail holds the one word that can arrive while the
// head is stalled.
module stream_skid_buffer
  import fifo_read_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output occ_t                  occ,
  output logic                  valid
);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  occ_t                  occ_q, occ_d;

  // Next buffer contents from the push/pop combination.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = push_data;
        else               tail_d = push_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Occupancy holds; the new word lands behind whatever remains.
        if (occ_q == 2'd2) begin
          head_d = tail_q;
          tail_d = push_data;
        end else begin
          head_d = push_data;
        end
      end
      default: ;
    endcase
  end

  // Buffer registers; reset empties the buffer and clears stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign head  = head_q;
  assign occ   = occ_q;
  assign valid = (occ_q != 2'd0);

`ifndef SYNTHESIS
  // The read-issue credit check must never let the buffer overflow.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (occ_q <= 2'd2);
      assert (!(push && !pop && occ_q == 2'd2));
    end
  end
`endif

endmodule

// File: rtl/fifo_read_streamer.sv
// Read-domain consumer for the async FIFO: issues reads against empty flag and
// buffer credit, absorbs the one-cycle RAM latency, and frames the output
// stream into PKT_LEN-beat packets.
module fifo_read_streamer
  import fifo_read_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PKT_LEN    = DEF_PKT_LEN,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk_read,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  Read_enable,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  beat_count
);

  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(PKT_LEN - 1);

  logic                  inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  pop;
  logic                  buf_valid;
  occ_t                  occ;
  logic [DATA_WIDTH-1:0] head;

  assign pop = m_valid & m_ready;

  // Issue a read only when the word can be guaranteed a buffer slot two
  // cycles out. Gating with reset keeps the strobe low while held in reset.
  always_comb begin
    Read_enable = reset & enable & ~fifo_empty &
                  (credit_sum(occ, inflight_q, pop) <= 3'd1);
    inflight_d  = Read_enable;
  end

  // Beat index within the packet; only advances on an accepted beat.
  always_comb begin
    cnt_d = cnt_q;
    if (pop) cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + 1'b1;
  end

  // Inflight flag and beat counter; reset drops any word in flight.
  always_ff @(posedge clk_read or negedge reset) begin
    if (!reset) begin
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
    end
  end

  stream_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk_read),
    .rst_n    (reset),
    .push     (inflight_q),
    .push_data(fifo_data),
    .pop      (pop),
    .head     (head),
    .occ      (occ),
    .valid    (buf_valid)
  );

  assign m_valid    = buf_valid;
  assign m_data     = head;
  assign beat_count = cnt_q;
  assign m_last     = buf_valid & (cnt_q == LAST_BEAT);

endmodule
